instr_fetch_queue: RTL and testbench

//  Parametrised successor to the combinational instruction ROM: registered-read instruction memory plus an

---
 rtl/instr_fetch_queue.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: registered-read instruction memory with an internal fetch
// PC and a small prefetch FIFO that feeds the IF/ID stage over valid/ready.
// Ports:
//   clk, reset (async, active-low)
//   redirect_valid/redirect_addr : branch/jump redirect, flushes the queue
//   instr_ready                  : decode accepts the head entry
//   instr_valid/instr_data/_h/_l : head entry, data split into hi/lo bytes
//   instr_pc/instr_fault         : byte PC of the head entry, bad-PC tag
//   fetch_pc                     : next byte address to be issued (debug)
module instr_fetch_queue #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0,
  parameter              INIT_FILE  = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [7:0]        instr_data_h,
  output logic [7:0]        instr_data_l,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_fault,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Instruction image; cleared once at elaboration, never touched by reset.
  logic [DATA_W-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  // In-flight read slot (memory output register)
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
  logic              rd_fault_q, rd_fault_d;

  // Prefetch storage; validity is tracked by count/pointers only
  logic [DATA_W-1:0] fifo_data_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic              fifo_fault_q [FIFO_DEPTH];

  logic [ADDR_W-1:0] word_idx_c;
  logic              misaligned_c;
  logic              out_of_range_c;
  logic              issue_fault_c;
  logic              space_c;
  logic              issue_c;
  logic              push_c;
  logic              pop_c;
  logic              head_valid_c;

  // Address decode for the PC about to be issued
  assign word_idx_c     = fetch_pc_q >> SHIFT;
  assign misaligned_c   = (fetch_pc_q & ADDR_W'(BYTES - 1)) != '0;
  assign out_of_range_c = 32'(word_idx_c) >= 32'(DEPTH);
  assign issue_fault_c  = misaligned_c | out_of_range_c;

  // Space check counts the in-flight read and ignores a same-cycle pop
  assign space_c      = (32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH;
  assign issue_c      = space_c && !redirect_valid;
  assign push_c       = inflight_q && !redirect_valid;
  assign head_valid_c = count_q != '0;
  assign pop_c        = head_valid_c && instr_ready;

  // Next-state for PC, in-flight flag and FIFO bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pc_d    = fetch_pc_q;
    rd_fault_d = issue_fault_c;
    rd_data_d  = issue_fault_c ? '0 : mem[IDX_W'(word_idx_c)];
    if (redirect_valid) begin
      // Flush everything, including the in-flight read
      fetch_pc_d = redirect_addr;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue_c) fetch_pc_d = fetch_pc_q + ADDR_W'(BYTES);
      inflight_d = issue_c;
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= ADDR_W'(RESET_PC);
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Synchronous memory read into the in-flight slot
  always_ff @(posedge clk) begin
    if (issue_c) begin
      rd_data_q  <= rd_data_d;
      rd_pc_q    <= rd_pc_d;
      rd_fault_q <= rd_fault_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_data_q[wr_ptr_q]  <= rd_data_q;
      fifo_pc_q[wr_ptr_q]    <= rd_pc_q;
      fifo_fault_q[wr_ptr_q] <= rd_fault_q;
    end
  end

  // Head entry; forced to zero when empty so reset/flush show clean outputs
  assign instr_valid  = head_valid_c;
  assign instr_data   = head_valid_c ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc     = head_valid_c ? fifo_pc_q[rd_ptr_q] : '0;
  assign instr_fault  = head_valid_c ? fifo_fault_q[rd_ptr_q] : 1'b0;
  assign instr_data_h = instr_data[DATA_W-1 -: 8];
  assign instr_data_l = instr_data[7:0];
  assign fetch_pc     = fetch_pc_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios followed by random
// ready/redirect traffic, checked against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int FD    = 4;
  localparam int DEPTH = 128;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [7:0]  instr_data_h;
  logic [7:0]  instr_data_l;
  logic [15:0] instr_pc;
  logic        instr_fault;
  logic [15:0] fetch_pc;

  instr_fetch_queue #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .FIFO_DEPTH(FD), .RESET_PC(0), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_data_h(instr_data_h), .instr_data_l(instr_data_l),
    .instr_pc(instr_pc), .instr_fault(instr_fault), .fetch_pc(fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
    logic        fault;
  } ent_t;

  logic [15:0] img [DEPTH];
  ent_t        q [$];
  ent_t        m_ent;
  logic        m_inf;
  logic [15:0] m_pc;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // What decode should receive for a fetch at byte address pc
  function automatic ent_t fetch_model(input logic [15:0] pc);
    ent_t e;
    e.pc    = pc;
    e.fault = pc[0] || (int'(pc) / 2 >= DEPTH);
    e.data  = e.fault ? 16'h0 : img[int'(pc) / 2];
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_inf = 1'b0;
    m_pc  = 16'h0;
  endtask

  task automatic check_head();
    chk("valid", 32'(instr_valid), 32'(q.size() != 0));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_pc));
    if (q.size() != 0) begin
      chk("pc", 32'(instr_pc), 32'(q[0].pc));
      chk("data", 32'(instr_data), 32'(q[0].data));
      chk("fault", 32'(instr_fault), 32'(q[0].fault));
      chk("data_h", 32'(instr_data_h), 32'(q[0].data[15:8]));
      chk("data_l", 32'(instr_data_l), 32'(q[0].data[7:0]));
    end
  endtask

  // Drive one cycle of inputs (called at negedge), advance the model across
  // the coming rising edge, then compare at the following negedge.
  task automatic step(input logic rdy, input logic rv, input logic [15:0] ra);
    int occ;
    logic iss;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_addr  = ra;
    if (rv) begin
      q.delete();
      m_inf = 1'b0;
      m_pc  = ra;
    end else begin
      occ = q.size() + int'(m_inf);
      iss = occ < FD;
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (m_inf) q.push_back(m_ent);
      if (iss) begin
        m_ent = fetch_model(m_pc);
        m_pc  = m_pc + 16'd2;
      end
      m_inf = iss;
    end
    @(posedge clk);
    @(negedge clk);
    check_head();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0;
    model_reset();
    #1;
    for (int i = 0; i < DEPTH; i++) img[i] = 16'($urandom);
    img[0]  = 16'h1111;
    img[1]  = 16'h2222;
    img[2]  = 16'h3333;
    img[3]  = 16'h4444;
    img[14] = 16'hE0E0;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = img[i];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_data", 32'(instr_data), 32'd0);
    chk("rst_h", 32'(instr_data_h), 32'd0);
    chk("rst_l", 32'(instr_data_l), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_fault", 32'(instr_fault), 32'd0);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'd0);
    reset = 1'b1;

    // Straight-line fetch: first valid after the second edge
    step(1'b1, 1'b0, 16'h0);
    chk("t1_not_yet", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'h0);
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_pc", 32'(instr_pc), 32'(2 * i));
      chk("t1_data", 32'(instr_data), 32'(16'h1111 * (i + 1)));
      chk("t1_h", 32'(instr_data_h), 32'(8'h11 * (i + 1)));
    end

    // Back-pressure: queue saturates, PC stops, head holds, drains in order
    @(negedge clk);
    do_reset();
    repeat (10) step(1'b0, 1'b0, 16'h0);
    chk("t2_fetch_pc", 32'(fetch_pc), 32'd8);
    chk("t2_head_pc", 32'(instr_pc), 32'd0);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    step(1'b1, 1'b0, 16'h0);
    chk("t2_drain_pc", 32'(instr_pc), 32'd2);
    repeat (8) step(1'b1, 1'b0, 16'h0);

    // Redirect with three entries queued and one read in flight
    do_reset();
    repeat (4) step(1'b0, 1'b0, 16'h0);
    chk("t3_fetch_pc", 32'(fetch_pc), 32'd8);
    step(1'b0, 1'b1, 16'h001C);
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 16'h0);
    chk("t3_gap", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 16'h0);
    chk("t3_valid", 32'(instr_valid), 32'd1);
    chk("t3_pc", 32'(instr_pc), 32'h001C);
    chk("t3_data", 32'(instr_data), 32'hE0E0);
    repeat (3) step(1'b1, 1'b0, 16'h0);

    // Fault tagging: odd PC, then first word past the end of memory
    step(1'b1, 1'b1, 16'h0101);
    repeat (2) step(1'b1, 1'b0, 16'h0);
    chk("t4_odd_pc", 32'(instr_pc), 32'h0101);
    chk("t4_odd_fault", 32'(instr_fault), 32'd1);
    chk("t4_odd_data", 32'(instr_data), 32'd0);
    step(1'b1, 1'b1, 16'(DEPTH * 2));
    repeat (2) step(1'b1, 1'b0, 16'h0);
    chk("t4_oor_pc", 32'(instr_pc), 32'(DEPTH * 2));
    chk("t4_oor_fault", 32'(instr_fault), 32'd1);
    chk("t4_oor_data", 32'(instr_data), 32'd0);

    // Reset asserted mid-drain: valid drops before the next edge
    step(1'b1, 1'b1, 16'h0020);
    repeat (4) step(1'b1, 1'b0, 16'h0);
    chk("t5_pre_valid", 32'(instr_valid), 32'd1);
    #1;
    do_reset();
    repeat (2) step(1'b1, 1'b0, 16'h0);
    chk("t5_restart_pc", 32'(instr_pc), 32'd0);

    // Back-to-back redirects: the last one wins
    step(1'b1, 1'b1, 16'h0010);
    step(1'b1, 1'b1, 16'h0040);
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    chk("t6_pc", 32'(instr_pc), 32'h0040);
    step(1'b1, 1'b0, 16'h0);
    chk("t6_next_pc", 32'(instr_pc), 32'h0042);

    // Random ready/redirect traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic rdy;
      logic rv;
      logic [15:0] ra;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      ra  = 16'($urandom_range(0, 300));
      if ($urandom_range(0, 3) != 0) ra[0] = 1'b0;
      step(rdy, rv, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
